// File: rtl/memoria_dual_param.sv
// True dual-port RAM: two independent read/write ports on one DEPTH x DATA_W array,
// registered read data with a one-cycle valid pulse, port A priority on write conflicts.
module memoria_dual_param #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 3,
    parameter int READ_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enA,
    input  logic              enB,
    input  logic              rwA,
    input  logic              rwB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] DataInA,
    input  logic [DATA_W-1:0] DataInB,
    output logic [DATA_W-1:0] DataOutA,
    output logic [DATA_W-1:0] DataOutB,
    output logic              validA,
    output logic              validB,
    output logic              collision
);

    localparam int DEPTH       = 2 ** ADDR_W;
    localparam bit WRITE_FIRST = (READ_MODE == 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [DATA_W-1:0] dout_a_q, dout_a_d;
    logic [DATA_W-1:0] dout_b_q, dout_b_d;
    logic              valid_a_q, valid_a_d;
    logic              valid_b_q, valid_b_d;
    logic              collision_q, collision_d;

    logic              wr_a, wr_b_req, wr_b;
    logic              rd_a, rd_b;
    logic              same_addr;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    // Port decode. A same-address dual write keeps port A and drops port B.
    assign same_addr = (AddrA == AddrB);
    assign wr_a      = enA & rwA;
    assign wr_b_req  = enB & rwB;
    assign wr_b      = wr_b_req & ~(wr_a & same_addr);
    assign rd_a      = enA & ~rwA;
    assign rd_b      = enB & ~rwB;

    // Cross-port read-during-write: write-first forwards the other port's write data.
    always_comb begin
        rdata_a = mem_q[AddrA];
        rdata_b = mem_q[AddrB];
        if (WRITE_FIRST) begin
            if (wr_b && same_addr) rdata_a = DataInB;
            if (wr_a && same_addr) rdata_b = DataInA;
        end
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (wr_b) mem_d[AddrB] = DataInB;
        if (wr_a) mem_d[AddrA] = DataInA;
    end

    always_comb begin
        dout_a_d    = dout_a_q;
        dout_b_d    = dout_b_q;
        valid_a_d   = rd_a;
        valid_b_d   = rd_b;
        collision_d = wr_a & wr_b_req & same_addr;
        if (rd_a) dout_a_d = rdata_a;
        if (rd_b) dout_b_d = rdata_b;
    end

    // NOTE: the array lives in flops rather than a RAM macro because every word
    // must clear asynchronously with reset; sequential state uses non-blocking '<='.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            valid_a_q   <= valid_a_d;
            valid_b_q   <= valid_b_d;
            collision_q <= collision_d;
        end
    end

    assign DataOutA  = dout_a_q;
    assign DataOutB  = dout_b_q;
    assign validA    = valid_a_q;
    assign validB    = valid_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_memoria_dual_param.sv
// Self-checking bench: read-first and write-first 4x8 instances plus an 8-bit x 32-word
// instance, compared every cycle against an array-based reference model.
module tb_memoria_dual_param;

    logic       clk;
    logic       reset_L;

    logic       enA, enB, rwA, rwB;
    logic [2:0] AddrA, AddrB;
    logic [3:0] DataInA, DataInB;
    logic [3:0] out_a0, out_b0, out_a1, out_b1;
    logic       va0, vb0, col0, va1, vb1, col1;

    logic       w_enA, w_enB, w_rwA, w_rwB;
    logic [4:0] w_AddrA, w_AddrB;
    logic [7:0] w_DataInA, w_DataInB;
    logic [7:0] w_out_a, w_out_b;
    logic       w_va, w_vb, w_col;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] mem_m [8];
    logic [3:0] exp_oa0, exp_ob0, exp_oa1, exp_ob1;
    logic       exp_va, exp_vb, exp_col;
    logic [7:0] wmem_m [32];
    logic [7:0] w_exp_oa, w_exp_ob;
    logic       w_exp_va, w_exp_vb, w_exp_col;

    memoria_dual_param #(.DATA_W(4), .ADDR_W(3), .READ_MODE(0)) u_rf (
        .clk(clk), .reset_L(reset_L),
        .enA(enA), .enB(enB), .rwA(rwA), .rwB(rwB),
        .AddrA(AddrA), .AddrB(AddrB), .DataInA(DataInA), .DataInB(DataInB),
        .DataOutA(out_a0), .DataOutB(out_b0),
        .validA(va0), .validB(vb0), .collision(col0)
    );

    memoria_dual_param #(.DATA_W(4), .ADDR_W(3), .READ_MODE(1)) u_wf (
        .clk(clk), .reset_L(reset_L),
        .enA(enA), .enB(enB), .rwA(rwA), .rwB(rwB),
        .AddrA(AddrA), .AddrB(AddrB), .DataInA(DataInA), .DataInB(DataInB),
        .DataOutA(out_a1), .DataOutB(out_b1),
        .validA(va1), .validB(vb1), .collision(col1)
    );

    memoria_dual_param #(.DATA_W(8), .ADDR_W(5), .READ_MODE(0)) u_wide (
        .clk(clk), .reset_L(reset_L),
        .enA(w_enA), .enB(w_enB), .rwA(w_rwA), .rwB(w_rwB),
        .AddrA(w_AddrA), .AddrB(w_AddrB), .DataInA(w_DataInA), .DataInB(w_DataInB),
        .DataOutA(w_out_a), .DataOutB(w_out_b),
        .validA(w_va), .validB(w_vb), .collision(w_col)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mem_m[i]) mem_m[i] = '0;
        foreach (wmem_m[i]) wmem_m[i] = '0;
        {exp_oa0, exp_ob0, exp_oa1, exp_ob1, exp_va, exp_vb, exp_col} = '0;
        {w_exp_oa, w_exp_ob, w_exp_va, w_exp_vb, w_exp_col} = '0;
    endtask

    // Reference behaviour for one rising edge: reads see the old contents (or the
    // other port's write data in write-first mode), then writes land, port A last.
    task automatic model_step();
        logic wa, wb, ra, rb;
        if (!reset_L) begin
            model_reset();
            return;
        end
        wa = enA && rwA;  wb = enB && rwB;
        ra = enA && !rwA; rb = enB && !rwB;
        exp_va  = ra;
        exp_vb  = rb;
        exp_col = wa && wb && (AddrA == AddrB);
        if (ra) begin
            exp_oa0 = mem_m[AddrA];
            exp_oa1 = (wb && AddrB == AddrA) ? DataInB : mem_m[AddrA];
        end
        if (rb) begin
            exp_ob0 = mem_m[AddrB];
            exp_ob1 = (wa && AddrA == AddrB) ? DataInA : mem_m[AddrB];
        end
        if (wb) mem_m[AddrB] = DataInB;
        if (wa) mem_m[AddrA] = DataInA;

        wa = w_enA && w_rwA;  wb = w_enB && w_rwB;
        ra = w_enA && !w_rwA; rb = w_enB && !w_rwB;
        w_exp_va  = ra;
        w_exp_vb  = rb;
        w_exp_col = wa && wb && (w_AddrA == w_AddrB);
        if (ra) w_exp_oa = wmem_m[w_AddrA];
        if (rb) w_exp_ob = wmem_m[w_AddrB];
        if (wb) wmem_m[w_AddrB] = w_DataInB;
        if (wa) wmem_m[w_AddrA] = w_DataInA;
    endtask

    task automatic check_all(input string ph);
        check({ph, ".rf_outA"}, out_a0, exp_oa0);
        check({ph, ".rf_outB"}, out_b0, exp_ob0);
        check({ph, ".rf_vA"},   va0,    exp_va);
        check({ph, ".rf_vB"},   vb0,    exp_vb);
        check({ph, ".rf_col"},  col0,   exp_col);
        check({ph, ".wf_outA"}, out_a1, exp_oa1);
        check({ph, ".wf_outB"}, out_b1, exp_ob1);
        check({ph, ".wf_vA"},   va1,    exp_va);
        check({ph, ".wf_vB"},   vb1,    exp_vb);
        check({ph, ".wf_col"},  col1,   exp_col);
        check({ph, ".w_outA"},  w_out_a, w_exp_oa);
        check({ph, ".w_outB"},  w_out_b, w_exp_ob);
        check({ph, ".w_vA"},    w_va,    w_exp_va);
        check({ph, ".w_vB"},    w_vb,    w_exp_vb);
        check({ph, ".w_col"},   w_col,   w_exp_col);
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next one.
    task automatic cycle(input string ph);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic ops(input logic ea, input logic wra, input logic [2:0] aa, input logic [3:0] da,
                       input logic eb, input logic wrb, input logic [2:0] ab, input logic [3:0] db);
        enA = ea; rwA = wra; AddrA = aa; DataInA = da;
        enB = eb; rwB = wrb; AddrB = ab; DataInB = db;
    endtask

    task automatic wops(input logic ea, input logic wra, input logic [4:0] aa, input logic [7:0] da,
                        input logic eb, input logic wrb, input logic [4:0] ab, input logic [7:0] db);
        w_enA = ea; w_rwA = wra; w_AddrA = aa; w_DataInA = da;
        w_enB = eb; w_rwB = wrb; w_AddrB = ab; w_DataInB = db;
    endtask

    initial begin
        reset_L = 1'b1;
        ops(0, 0, 0, 0, 0, 0, 0, 0);
        wops(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2 reset_L = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        reset_L = 1'b1;

        // Basic write then read on the other port.
        ops(1, 1, 3, 4'hA, 0, 0, 0, 0);   cycle("r20_wr");
        ops(0, 0, 0, 0, 1, 0, 3, 0);      cycle("r20_rd");
        check("r20_doutB", out_b0, 4'hA);
        check("r20_validB", vb0, 1'b1);
        check("r20_collision", col0, 1'b0);

        // Dual write to the same address: port A wins, flag lasts one cycle.
        ops(1, 1, 6, 4'h5, 1, 1, 6, 4'h9); cycle("r21_ww");
        check("r21_col_set", col0, 1'b1);
        ops(0, 0, 0, 0, 0, 0, 0, 0);       cycle("r21_idle");
        check("r21_col_clear", col0, 1'b0);
        ops(0, 0, 0, 0, 1, 0, 6, 0);       cycle("r21_rd");
        check("r21_doutB", out_b0, 4'h5);

        // Read during write on the same address, both read modes.
        ops(1, 1, 2, 4'h1, 0, 0, 0, 0);    cycle("r22_init");
        ops(1, 1, 2, 4'hF, 1, 0, 2, 0);    cycle("r22_rdw");
        check("r22_rf_doutB", out_b0, 4'h1);
        check("r22_wf_doutB", out_b1, 4'hF);
        check("r22_col", col0, 1'b0);

        // Hold: read then three idle cycles.
        ops(1, 1, 0, 4'h7, 0, 0, 0, 0);    cycle("r23_init");
        ops(1, 0, 0, 0, 0, 0, 0, 0);       cycle("r23_rd");
        check("r23_validA_rd", va0, 1'b1);
        check("r23_doutA_rd", out_a0, 4'h7);
        for (int i = 0; i < 3; i++) begin
            ops(0, 0, 0, 0, 0, 0, 0, 0);   cycle("r23_idle");
            check("r23_validA_idle", va0, 1'b0);
            check("r23_doutA_idle", out_a0, 4'h7);
        end

        // Back-to-back reads keep valid high; both ports reading one address.
        ops(1, 0, 3, 0, 1, 0, 3, 0);       cycle("r14_rr1");
        ops(1, 0, 6, 0, 1, 0, 6, 0);       cycle("r14_rr2");
        check("r10_validA_b2b", va0, 1'b1);
        check("r14_doutA", out_a0, 4'h5);
        check("r14_doutB", out_b0, 4'h5);
        check("r14_col", col0, 1'b0);

        // Wide instance: top address and independence from address 0.
        ops(0, 0, 0, 0, 0, 0, 0, 0);
        wops(1, 1, 31, 8'hC3, 0, 0, 0, 0); cycle("r25_wr31");
        wops(1, 1, 0, 8'h5A, 0, 0, 0, 0);  cycle("r25_wr0");
        wops(1, 0, 31, 0, 1, 0, 0, 0);     cycle("r25_rd");
        check("r25_dout31", w_out_a, 8'hC3);
        check("r25_dout0", w_out_b, 8'h5A);
        wops(0, 0, 0, 0, 0, 0, 0, 0);

        // Fill all words nonzero, read, then async reset between edges.
        for (int i = 0; i < 8; i++) begin
            ops(1, 1, 3'(i), 4'(i + 9), 0, 0, 0, 0); cycle("r24_fill");
        end
        ops(1, 0, 5, 0, 1, 0, 7, 0);       cycle("r24_pre");
        check("r24_pre_doutA", out_a0, 4'hE);
        #2 reset_L = 1'b0;
        model_reset();
        #1 check_all("r24_async");
        ops(1, 1, 1, 4'h9, 1, 0, 1, 0);    cycle("r24_in_reset");
        reset_L = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ops(1, 0, 3'(i), 0, 1, 0, 3'(7 - i), 0); cycle("r24_rd");
            check("r24_cleared", out_a0, 4'h0);
        end

        // Randomized traffic, biased towards address conflicts.
        for (int n = 0; n < 400; n++) begin
            ops(($urandom % 4) != 0, 1'($urandom), 3'($urandom), 4'($urandom),
                ($urandom % 4) != 0, 1'($urandom), 3'($urandom), 4'($urandom));
            if ($urandom % 3 == 0) AddrB = AddrA;
            wops(($urandom % 4) != 0, 1'($urandom), 5'($urandom % 8), 8'($urandom),
                 ($urandom % 4) != 0, 1'($urandom), 5'($urandom % 8), 8'($urandom));
            if ($urandom % 3 == 0) w_AddrB = w_AddrA;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
